// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  // Quotient reported when the divisor is zero (all ones at the default width).
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/result bus between the control unit (master) and the divider (slave).
interface div_seq_ctrl_if #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step.
module div_step #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] new_rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The full remainder is shifted into a WIDTH+1 bit value so divisors with
  // the top bit set still divide correctly; a kept (non-subtracted) value is
  // always below the divisor and therefore fits back into WIDTH bits.
  always_comb begin
    shifted   = {rem_i, q_msb_i};
    trial     = shifted - {1'b0, divisor_i};
    q_bit_o   = ~trial[WIDTH];
    new_rem_o = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: WIDTH iterations, registered results, done pulse.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  div_seq_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_msb_i   (q_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .new_rem_o (step_rem),
    .q_bit_o   (step_bit)
  );

  // Next-state, working registers and result loading; results are loaded on
  // the edge entering FIN so they are visible together with done.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            q_d     = bus.dividend;
            rem_d   = '0;
            dvs_d   = bus.divisor;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = RUN;
          end else begin
            quot_d  = '1;
            remo_d  = bus.dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        q_d   = {q_q[WIDTH-2:0], step_bit};
        rem_d = step_rem;
        if (cnt_q == '0) begin
          quot_d  = q_d;
          remo_d  = step_rem;
          dbz_d   = 1'b0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working and output registers; busy/done are registered state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == FIN);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: driver predicts results and timing from
// plain arithmetic, a monitor compares every cycle.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int W = 8;

  typedef struct {
    int           dc;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  div_seq_ctrl_if #(.WIDTH(W)) bus_if ();

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  exp_t last;
  int   busy_first = 0;
  int   busy_last  = -1;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model;
    sb.delete();
    busy_first = 0;
    busy_last  = -1;
    last.dc    = 0;
    last.q     = '0;
    last.r     = '0;
    last.dbz   = 1'b0;
  endtask

  // Raise start for one cycle; a request is taken only outside a busy window.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    bus_if.start    = 1'b1;
    bus_if.dividend = dvd;
    bus_if.divisor  = dvs;
    if (cyc > busy_last) begin
      if (dvs == '0) begin
        e.dc  = cyc + 1;
        e.q   = DBZ_QUOTIENT;
        e.r   = dvd;
        e.dbz = 1'b1;
      end else begin
        e.dc       = cyc + W + 1;
        e.q        = dvd / dvs;
        e.r        = dvd % dvs;
        e.dbz      = 1'b0;
        busy_first = cyc + 1;
        busy_last  = cyc + W;
      end
      sb.push_back(e);
    end
    tick();
    bus_if.start    = 1'b0;
    bus_if.dividend = W'($urandom);
    bus_if.divisor  = W'($urandom);
  endtask

  task automatic wait_free;
    while (cyc <= busy_last) tick();
  endtask

  task automatic check_reset_outputs;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_quotient", 32'(bus_if.quotient), 32'd0);
    chk("rst_remainder", 32'(bus_if.remainder), 32'd0);
    chk("rst_dbz", 32'(bus_if.div_by_zero), 32'd0);
  endtask

  // Monitor: done timing, busy window and held result values every cycle.
  always @(negedge clk) begin : mon
    logic exp_done;
    if (rst_n) begin
      exp_done = (sb.size() > 0) && (sb[0].dc == cyc);
      chk("done", 32'(bus_if.done), 32'(exp_done));
      if (exp_done) last = sb.pop_front();
      chk("busy", 32'(bus_if.busy), 32'(cyc >= busy_first && cyc <= busy_last));
      chk("quotient", 32'(bus_if.quotient), 32'(last.q));
      chk("remainder", 32'(bus_if.remainder), 32'(last.r));
      chk("div_by_zero", 32'(bus_if.div_by_zero), 32'(last.dbz));
    end
  end

  logic [W-1:0] cv[7];

  initial begin
    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    clear_model();

    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 100/7: busy cycles 1..8, done cycle 9 with 14 r 2
    issue(8'd100, 8'd7);
    wait_free();
    tick();

    // divide by zero: done next cycle, busy never rises
    issue(8'd5, 8'd0);
    tick();
    tick();

    // back-to-back: second start held in the first done cycle
    issue(8'd3, 8'd10);
    wait_free();
    issue(8'd255, 8'd1);
    wait_free();
    tick();

    // start while busy is ignored
    issue(8'd200, 8'd3);
    repeat (3) tick();
    issue(8'd9, 8'd9);
    wait_free();
    tick();

    // reset in cycle 5 of a run: outputs clear at once, no done afterwards
    issue(8'd50, 8'd7);
    repeat (4) tick();
    rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();

    // operand corners
    cv = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        wait_free();
        issue(cv[i], cv[j]);
      end
    end

    // random traffic with gaps, back-to-back starts and starts while busy
    for (int n = 0; n < 1500; n++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0 && cyc <= busy_last) begin
        issue(a, b);
      end else begin
        wait_free();
        repeat ($urandom_range(0, 2)) tick();
        issue(a, b);
      end
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
